wdt_reset_ctrl: RTL
===================

// Module: wdt_reset_ctrl
// PURPOSE
//  Reset controller that consumes the watchdog o_timeout strobe and the CPU soft-reset request.
//  Drives the system reset for the riscv32 core, peripherals and the watchdog itself.
//  Synchronises external reset release and stretches every reset to a fixed hold time.
//  Latches the last reset cause and a watchdog-reset count for firmware to read after boot.
// PARAMETERS
//  HOLD_CYCLES      16  cycles o_sys_resetn is held low per reset (>=1)
//  COOLDOWN_CYCLES  4   cycles after release during which new triggers are ignored (>=1)
//  CNT_W            8   width of watchdog-reset counter
// PORTS
//  i_clk            in   1      system clock
//  i_resetn         in   1      reset, asynchronous, active-low (power-on / button)
//  i_wdt_timeout    in   1      watchdog timeout level, synchronous to i_clk
//  i_sw_reset_req   in   1      one-cycle soft-reset request from CPU register write
//  i_cause_clr      in   1      one-cycle strobe: clear cause and counter
//  o_sys_resetn     out  1      system reset, active-low; async assert, sync release
//  o_reset_active   out  1      1 whenever state != RUN
//  o_reset_cause    out  2      00 none/cleared, 01 POR, 10 watchdog, 11 software
//  o_wdt_count      out  CNT_W  saturating count of watchdog-triggered resets
// BEHAVIOUR
//  - Reset i_resetn, asynchronous, active-low; clock i_clk.
//  - While i_resetn=0: o_sys_resetn=0, o_reset_active=1, state=POR, cause=01, count=0,
//    2-flop release synchroniser=00, timeout edge register=0, hold counter=HOLD_CYCLES-1.
//  - States: POR, HOLD, COOLDOWN, RUN; one down-counter shared by POR/HOLD/COOLDOWN.
//  - POR: wait for synchroniser output=1 (2 edges after i_resetn rises), then count
//    HOLD_CYCLES edges -> RUN. o_sys_resetn rises on edge HOLD_CYCLES+2 after release.
//    No COOLDOWN after POR.
//  - Triggers: wdt_trig = i_wdt_timeout & ~tmo_q (rising edge; tmo_q registered every cycle).
//    Triggers are acted on only in RUN.
//  - RUN + wdt_trig at edge N: at edge N
//    - state=HOLD, o_sys_resetn=0;
//    - cause=10;
//    - count+1, saturating at all-ones.
//  - RUN + i_sw_reset_req at edge N: same, but cause=11; count unchanged.
//  - Both triggers in the same cycle: watchdog wins (cause=10, count increments).
//  - HOLD: o_sys_resetn=0 for exactly HOLD_CYCLES cycles.
//    Then COOLDOWN with o_sys_resetn=1 for COOLDOWN_CYCLES cycles, then RUN.
//  - Triggers in HOLD/COOLDOWN are dropped, not queued.
//  - A timeout level still high on entering RUN does not retrigger (no edge).
//  - i_cause_clr in any state: cause=00, count=0 next edge.
//    If it coincides with a trigger, the trigger result wins (cause set, count=1 for wdt).
//  - Cause and count survive HOLD; only i_resetn or i_cause_clr alter them otherwise.
//  - i_resetn low mid-HOLD/COOLDOWN: immediate async return to POR values, no glitch high.
//  - o_reset_active=1 in POR/HOLD/COOLDOWN, 0 in RUN; all outputs registered.
// TESTING
//  - POR, HOLD=16: release i_resetn at edge 0
//    -> o_sys_resetn=1 at edge 18, cause=01, count=0, o_reset_active=0.
//  - RUN, i_wdt_timeout rises (level held 3 cycles)
//    -> o_sys_resetn=0 next edge for 16 cycles, cause=10, count=1, single trigger only.
//  - i_wdt_timeout and i_sw_reset_req together -> cause=10, count=1.
//    Then sw req alone later -> cause=11, count=1.
//  - sw req during HOLD and during COOLDOWN -> ignored; total low time stays 16 cycles.
//  - Drive 300 watchdog resets with CNT_W=8 -> count=255 saturates.
//    Then i_cause_clr -> cause=00, count=0.
//  - Assert i_resetn=0 at HOLD cycle 5 -> o_sys_resetn=0 asynchronously, cause=01, count=0.
//    Release -> full POR sequence.

Source files
------------

// File: rtl/wdt_reset_ctrl.sv
// System reset controller: synchronises power-on release, stretches watchdog and
// software resets to a fixed hold time, and records the last reset cause and watchdog count.
module wdt_reset_ctrl #(
    parameter int HOLD_CYCLES     = 16,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_wdt_timeout,
    input  logic             i_sw_reset_req,
    input  logic             i_cause_clr,
    output logic             o_sys_resetn,
    output logic             o_reset_active,
    output logic [1:0]       o_reset_cause,
    output logic [CNT_W-1:0] o_wdt_count
);

    localparam int MAX_CYC = (HOLD_CYCLES > COOLDOWN_CYCLES) ? HOLD_CYCLES : COOLDOWN_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] COOL_LOAD = TMR_W'(COOLDOWN_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;
    localparam logic [1:0] CAUSE_SW   = 2'b11;

    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_HOLD = 2'd1,
        ST_COOL = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic [1:0]         r_sync;
    logic               r_tmo_q;
    logic [1:0]         r_cause;
    logic [1:0]         w_cause_nxt;
    logic [CNT_W-1:0]   r_wdt_count;
    logic [CNT_W-1:0]   w_wdt_count_nxt;
    logic               r_sys_resetn;
    logic               w_sys_resetn_nxt;
    logic               r_active;
    logic               w_active_nxt;

    logic               w_wdt_trig;
    logic               w_wdt_take;
    logic               w_sw_take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Watchdog timeout is a level; only its rising edge counts, and only while running
    assign w_wdt_trig = i_wdt_timeout & ~r_tmo_q;
    assign w_wdt_take = (r_state == ST_RUN) & w_wdt_trig;
    assign w_sw_take  = (r_state == ST_RUN) & ~w_wdt_trig & i_sw_reset_req;

    always_comb begin
        w_state_nxt      = r_state;
        w_tmr_nxt        = r_tmr;
        w_sys_resetn_nxt = r_sys_resetn;

        case (r_state)
            ST_POR: begin
                w_sys_resetn_nxt = 1'b0;
                if (r_sync[1]) begin
                    if (r_tmr == '0) begin
                        w_state_nxt      = ST_RUN;
                        w_sys_resetn_nxt = 1'b1;
                    end else begin
                        w_tmr_nxt = r_tmr - TMR_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                w_sys_resetn_nxt = 1'b0;
                if (r_tmr == '0) begin
                    w_state_nxt      = ST_COOL;
                    w_tmr_nxt        = COOL_LOAD;
                    w_sys_resetn_nxt = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            ST_COOL: begin
                w_sys_resetn_nxt = 1'b1;
                if (r_tmr == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            ST_RUN: begin
                w_sys_resetn_nxt = 1'b1;
                if (w_wdt_take || w_sw_take) begin
                    w_state_nxt      = ST_HOLD;
                    w_tmr_nxt        = HOLD_LOAD;
                    w_sys_resetn_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt      = ST_POR;
                w_tmr_nxt        = HOLD_LOAD;
                w_sys_resetn_nxt = 1'b0;
            end
        endcase

        w_active_nxt = (w_state_nxt != ST_RUN);
    end

    // Cause/count bookkeeping: an accepted trigger overrides a coincident clear
    always_comb begin
        w_cause_nxt     = r_cause;
        w_wdt_count_nxt = r_wdt_count;

        if (i_cause_clr) begin
            w_cause_nxt     = CAUSE_NONE;
            w_wdt_count_nxt = '0;
        end

        if (w_wdt_take) begin
            w_cause_nxt     = CAUSE_WDT;
            w_wdt_count_nxt = i_cause_clr ? CNT_W'(1) : sat_inc(r_wdt_count);
        end else if (w_sw_take) begin
            w_cause_nxt = CAUSE_SW;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state      <= ST_POR;
            r_tmr        <= HOLD_LOAD;
            r_sync       <= 2'b00;
            r_tmo_q      <= 1'b0;
            r_cause      <= CAUSE_POR;
            r_wdt_count  <= '0;
            r_sys_resetn <= 1'b0;
            r_active     <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_tmr        <= w_tmr_nxt;
            r_sync       <= {r_sync[0], 1'b1};
            r_tmo_q      <= i_wdt_timeout;
            r_cause      <= w_cause_nxt;
            r_wdt_count  <= w_wdt_count_nxt;
            r_sys_resetn <= w_sys_resetn_nxt;
            r_active     <= w_active_nxt;
        end
    end

    assign o_sys_resetn   = r_sys_resetn;
    assign o_reset_active = r_active;
    assign o_reset_cause  = r_cause;
    assign o_wdt_count    = r_wdt_count;

endmodule
